// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the RV32 instruction-fetch stage
// Rev 1.0
// ============================================================================
package fetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    KILL  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// fetch_if : ready/valid instruction-memory port of the fetch stage
// Rev 1.0
// ============================================================================
interface fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// ============================================================================
// fetch_hold_buf : one-entry {pc, instr} skid buffer (load / drain / clear)
// Rev 1.0
// ============================================================================
module fetch_hold_buf
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            load,
  input  wire logic            drain,
  input  wire logic            clear,
  input  wire logic [XLEN-1:0] load_pc,
  input  wire logic [31:0]     load_instr,
  output logic                 valid,
  output logic [XLEN-1:0]      pc,
  output logic [31:0]          instr
);

  // clear (redirect) beats load, load beats drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : RV32 IF stage - PC, imem request, IF/ID register, branch squash
// Optional misaligned-target pulse enabled by FETCH_MISALIGN_CHK_EN.  Rev 1.0
// ============================================================================
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            taken,
  input  wire logic [XLEN-1:0] branch_target,
  input  wire logic            stall,
  fetch_if.master              mem,
  output logic [XLEN-1:0]      if_id_pc,
  output logic [31:0]          if_id_instr,
  output logic                 if_id_valid
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic                 fetch_misaligned
`endif
);

  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_redir, w_redir_nxt;
  logic            r_run;
  logic [XLEN-1:0] w_if_pc_nxt;
  logic [31:0]     w_if_instr_nxt;
  logic            w_if_valid_nxt;
  logic            w_hold_load, w_hold_drain, w_hold_clear;
  logic            w_hold_valid;
  logic [XLEN-1:0] w_hold_pc;
  logic [31:0]     w_hold_instr;
  logic            w_req, w_accept;
  logic [XLEN-1:0] w_target;

  // Low target bits are dropped; the whole vector is consumed so nothing dangles.
  assign w_target = branch_target & ~XLEN'(3);

  // r_run delays the first request to the first edge after reset release.
  assign w_req    = r_run & ((r_state == KILL) | ~w_hold_valid);
  assign w_accept = w_req & mem.imem_ready;

  assign mem.imem_req  = w_req;
  assign mem.imem_addr = r_pc;

  fetch_hold_buf #(
    .XLEN (XLEN)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_hold_load),
    .drain      (w_hold_drain),
    .clear      (w_hold_clear),
    .load_pc    (r_pc),
    .load_instr (mem.imem_rdata),
    .valid      (w_hold_valid),
    .pc         (w_hold_pc),
    .instr      (w_hold_instr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run       <= 1'b0;
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_redir     <= '0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else begin
      r_run       <= 1'b1;
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_redir     <= w_redir_nxt;
      if_id_pc    <= w_if_pc_nxt;
      if_id_instr <= w_if_instr_nxt;
      if_id_valid <= w_if_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_redir_nxt    = r_redir;
    w_if_pc_nxt    = if_id_pc;
    w_if_instr_nxt = if_id_instr;
    w_if_valid_nxt = if_id_valid;
    w_hold_load    = 1'b0;
    w_hold_drain   = 1'b0;
    w_hold_clear   = 1'b0;

    case (r_state)
      FETCH: begin
        if (w_accept) begin
          if (taken) begin
            w_pc_nxt       = w_target;
            w_if_valid_nxt = 1'b0;
            w_hold_clear   = 1'b1;
          end else begin
            w_pc_nxt = r_pc + XLEN'(4);
            if (!stall) begin
              w_if_pc_nxt    = r_pc;
              w_if_instr_nxt = mem.imem_rdata;
              w_if_valid_nxt = 1'b1;
            end else begin
              w_hold_load = 1'b1;
            end
          end
        end else if (taken) begin
          w_if_valid_nxt = 1'b0;
          w_hold_clear   = 1'b1;
          // A raised request must stay stable, so park the target until it is accepted.
          if (w_req) begin
            w_redir_nxt = w_target;
            w_state_nxt = KILL;
          end else begin
            w_pc_nxt = w_target;
          end
        end else if (!stall) begin
          if (w_hold_valid) begin
            w_if_pc_nxt    = w_hold_pc;
            w_if_instr_nxt = w_hold_instr;
            w_if_valid_nxt = 1'b1;
            w_hold_drain   = 1'b1;
          end else begin
            w_if_valid_nxt = 1'b0;
          end
        end
      end

      KILL: begin
        if (taken) begin
          w_redir_nxt  = w_target;
          w_hold_clear = 1'b1;
        end
        if (w_accept) begin
          w_pc_nxt    = taken ? w_target : r_redir;
          w_state_nxt = FETCH;
        end
        if (!(stall && !taken)) begin
          w_if_valid_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_misaligned <= 1'b0;
    end else begin
      fetch_misaligned <= taken & (branch_target[1:0] != 2'b00);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage : table-driven directed bench for fetch_stage
// Rev 1.0
// ============================================================================
module tb_fetch_stage;
  import fetch_pkg::*;

  typedef struct packed {
    logic        tk;
    logic [31:0] tgt;
    logic        st;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  localparam int NVEC = 24;

  logic        clk;
  logic        rst_n;
  logic        taken;
  logic [31:0] branch_target;
  logic        stall;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        fetch_misaligned;
`endif

  int   n_vec;
  int   n_miss;
  vec_t vecs [NVEC];

  fetch_if #(.XLEN(32)) mem ();

  fetch_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .taken            (taken),
    .branch_target    (branch_target),
    .stall            (stall),
    .mem              (mem),
    .if_id_pc         (if_id_pc),
    .if_id_instr      (if_id_instr),
    .if_id_valid      (if_id_valid)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word at address a is a recognisable tag of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  always_comb mem.imem_rdata = mem_word(mem.imem_addr);

  function automatic vec_t mk(input logic tk, input logic [31:0] tgt, input logic st,
                              input logic rdy, input logic e_req, input logic [31:0] e_addr,
                              input logic e_vld, input logic [31:0] e_pc, input logic e_mis);
    vec_t v;
    v.tk = tk; v.tgt = tgt; v.st = st; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s [step %0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic tk, input logic [31:0] tgt, input logic st, input logic rdy);
    taken            = tk;
    branch_target    = tgt;
    stall            = st;
    mem.imem_ready   = rdy;
  endtask

  task automatic chk_reset_state(input int idx);
    chk("rst_req",   idx, 32'(mem.imem_req), 32'd0);
    chk("rst_addr",  idx, mem.imem_addr,     32'h0);
    chk("rst_valid", idx, 32'(if_id_valid),  32'd0);
    chk("rst_pc",    idx, if_id_pc,          32'h0);
    chk("rst_instr", idx, if_id_instr,       NOP_INSTR);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("rst_mis",   idx, 32'(fetch_misaligned), 32'd0);
`endif
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    //          tk  tgt            st  rdy | req addr          vld pc            mis
    vecs[0]  = mk(0, 32'h0,        0, 1,   0, 32'h0,        0, 32'h0,        0);
    vecs[1]  = mk(0, 32'h0,        0, 1,   1, 32'h0,        0, 32'h0,        0);
    vecs[2]  = mk(0, 32'h0,        0, 1,   1, 32'h4,        1, 32'h0,        0);
    vecs[3]  = mk(0, 32'h0,        1, 1,   1, 32'h8,        1, 32'h4,        0);
    vecs[4]  = mk(0, 32'h0,        1, 1,   0, 32'hC,        1, 32'h4,        0);
    vecs[5]  = mk(0, 32'h0,        0, 1,   0, 32'hC,        1, 32'h4,        0);
    vecs[6]  = mk(0, 32'h0,        0, 1,   1, 32'hC,        1, 32'h8,        0);
    vecs[7]  = mk(0, 32'h0,        0, 1,   1, 32'h10,       1, 32'hC,        0);
    vecs[8]  = mk(1, 32'h100,      0, 1,   1, 32'h14,       1, 32'h10,       0);
    vecs[9]  = mk(0, 32'h0,        0, 1,   1, 32'h100,      0, 32'h0,        0);
    vecs[10] = mk(0, 32'h0,        1, 1,   1, 32'h104,      1, 32'h100,      0);
    vecs[11] = mk(1, 32'h300,      1, 1,   0, 32'h108,      1, 32'h100,      0);
    vecs[12] = mk(0, 32'h0,        0, 0,   1, 32'h300,      0, 32'h0,        0);
    vecs[13] = mk(1, 32'h100,      0, 0,   1, 32'h300,      0, 32'h0,        0);
    vecs[14] = mk(1, 32'h200,      0, 0,   1, 32'h300,      0, 32'h0,        0);
    vecs[15] = mk(0, 32'h0,        0, 1,   1, 32'h300,      0, 32'h0,        0);
    vecs[16] = mk(0, 32'h0,        0, 1,   1, 32'h200,      0, 32'h0,        0);
    vecs[17] = mk(0, 32'h0,        0, 0,   1, 32'h204,      1, 32'h200,      0);
    vecs[18] = mk(1, 32'h102,      0, 1,   1, 32'h204,      0, 32'h0,        0);
    vecs[19] = mk(0, 32'h0,        0, 1,   1, 32'h100,      0, 32'h0,        1);
    vecs[20] = mk(1, 32'hFFFF_FFFC, 0, 1,  1, 32'h104,      1, 32'h100,      0);
    vecs[21] = mk(0, 32'h0,        0, 1,   1, 32'hFFFF_FFFC, 0, 32'h0,       0);
    vecs[22] = mk(0, 32'h0,        0, 1,   1, 32'h0,        1, 32'hFFFF_FFFC, 0);
    vecs[23] = mk(0, 32'h0,        0, 1,   1, 32'h4,        1, 32'h0,        0);

    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    chk_reset_state(-1);

    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].tk, vecs[i].tgt, vecs[i].st, vecs[i].rdy);
      #1;
      n_vec++;
      chk("imem_req",  i, 32'(mem.imem_req), 32'(vecs[i].e_req));
      chk("imem_addr", i, mem.imem_addr,     vecs[i].e_addr);
      chk("if_id_valid", i, 32'(if_id_valid), 32'(vecs[i].e_vld));
      if (vecs[i].e_vld) begin
        chk("if_id_pc",    i, if_id_pc,    vecs[i].e_pc);
        chk("if_id_instr", i, if_id_instr, mem_word(vecs[i].e_pc));
      end
`ifdef FETCH_MISALIGN_CHK_EN
      chk("fetch_misaligned", i, 32'(fetch_misaligned), 32'(vecs[i].e_mis));
`endif
    end

    // Asynchronous reset mid-stream, then a redirect issued under stall while imem is busy.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    chk_reset_state(100);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    @(negedge clk); #1;
    n_vec++;
    chk("rerun_req_low", 101, 32'(mem.imem_req), 32'd0);

    @(negedge clk); #1;
    n_vec++;
    chk("rerun_req",   102, 32'(mem.imem_req), 32'd1);
    chk("rerun_addr",  102, mem.imem_addr,     32'h0);
    chk("rerun_valid", 102, 32'(if_id_valid),  32'd0);

    @(negedge clk);
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    #1;
    n_vec++;
    chk("pc0_valid", 103, 32'(if_id_valid), 32'd1);
    chk("pc0_pc",    103, if_id_pc,         32'h0);
    chk("pc0_instr", 103, if_id_instr,      32'hA000_0000);
    chk("pc0_addr",  103, mem.imem_addr,    32'h4);

    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    n_vec++;
    chk("stall_taken_valid", 104, 32'(if_id_valid), 32'd0);
    chk("kill_addr",         104, mem.imem_addr,    32'h4);
    chk("kill_req",          104, 32'(mem.imem_req), 32'd1);

    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    n_vec++;
    chk("kill_hold_addr",  105, mem.imem_addr,    32'h4);
    chk("kill_hold_valid", 105, 32'(if_id_valid), 32'd0);

    @(negedge clk); #1;
    n_vec++;
    chk("redir_addr",  106, mem.imem_addr,    32'h40);
    chk("redir_valid", 106, 32'(if_id_valid), 32'd0);

    @(negedge clk); #1;
    n_vec++;
    chk("tgt_valid", 107, 32'(if_id_valid), 32'd1);
    chk("tgt_pc",    107, if_id_pc,         32'h40);
    chk("tgt_instr", 107, if_id_instr,      32'hA000_0040);
    chk("tgt_addr",  107, mem.imem_addr,    32'h44);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
